// File: rtl/code_lock_n_if.sv
// Button and display signals of the code lock.
// The bench drives the buttons through the master modport.
// The lock drives the display and status lines through the slave modport.
interface code_lock_n_if;
  logic       clr_in;
  logic       b0_in;
  logic       b1_in;
  logic       sel;
  logic       led_open;
  logic       led_alarm;
  logic [3:0] fail_cnt;
  logic [6:0] digital;

  modport master (
    output clr_in, b0_in, b1_in,
    input  sel, led_open, led_alarm, fail_cnt, digital
  );

  modport slave (
    input  clr_in, b0_in, b1_in,
    output sel, led_open, led_alarm, fail_cnt, digital
  );
endinterface

// File: rtl/code_lock_n.sv
// Serial code lock.
// The code is entered MSB first with the "0" and "1" buttons, and the clear button discards a partial entry.
// A correct code opens the lock, and the lock relocks after a timeout.
// MAX_TRIES consecutive failed codes put the lock into a timed lockout.
// The display shows the entry position, 'P' while open, or 'E' during lockout.
module code_lock_n #(
  parameter int                  CODE_LEN       = 4,
  parameter logic [CODE_LEN-1:0] CODE           = 4'b1011,
  parameter int                  MAX_TRIES      = 3,
  parameter int                  UNLOCK_CYCLES  = 100,
  parameter int                  LOCKOUT_CYCLES = 200
) (
  input logic           clk,
  input logic           reset,
  code_lock_n_if.slave  bus
);

  localparam int TMAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int CW   = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;

  localparam logic [CW-1:0] LAST_BIT    = CW'(CODE_LEN - 1);
  localparam logic [TW-1:0] UNLOCK_LAST = TW'((UNLOCK_CYCLES > 0) ? UNLOCK_CYCLES - 1 : 0);
  localparam logic [TW-1:0] LOCK_LAST   = TW'(LOCKOUT_CYCLES - 1);
  localparam logic [3:0]    TRIES_LIMIT = 4'(MAX_TRIES);

  typedef enum logic [1:0] {
    ENTRY   = 2'd0,
    OPEN    = 2'd1,
    LOCKOUT = 2'd2
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic          mismatch, mismatch_next;
  logic [3:0]    fail_cnt, fail_next;
  logic [TW-1:0] timer, timer_next;
  logic [2:0]    prev;
  logic [6:0]    seg;

  logic          clr_press, b0_press, b1_press, bit_press;
  logic          code_bit, bit_bad;
  logic [3:0]    fail_inc;
  logic [2:0]    cnt_disp;

  // A press is a rising level: the button is high now and was low on the previous cycle.
  assign clr_press = bus.clr_in & ~prev[2];
  assign b0_press  = bus.b0_in  & ~prev[1];
  assign b1_press  = bus.b1_in  & ~prev[0];
  assign bit_press = b0_press | b1_press;

  // Both bit buttons pressed together count as one bit that never matches.
  assign code_bit = CODE[LAST_BIT - cnt];
  assign bit_bad  = (b0_press & b1_press) | (b1_press != code_bit);
  assign fail_inc = fail_cnt + 4'd1;
  assign cnt_disp = 3'(cnt);

  // State and datapath registers.
  // The previous-value registers reset to 1 so that a button held through reset does not register as a press.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ENTRY;
      cnt      <= '0;
      mismatch <= 1'b0;
      fail_cnt <= 4'd0;
      timer    <= '0;
      prev     <= 3'b111;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      mismatch <= mismatch_next;
      fail_cnt <= fail_next;
      timer    <= timer_next;
      prev     <= {bus.clr_in, bus.b0_in, bus.b1_in};
    end
  end

  // Next-state logic and the display pattern.
  // Clear takes priority over a bit press in ENTRY.
  // The timer counts only in OPEN and LOCKOUT and is zero at the start of either state.
  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    mismatch_next = mismatch;
    fail_next     = fail_cnt;
    timer_next    = '0;
    seg           = 7'b0111111;

    case (state)
      ENTRY: begin
        if (clr_press) begin
          cnt_next      = '0;
          mismatch_next = 1'b0;
        end else if (bit_press) begin
          if (cnt == LAST_BIT) begin
            cnt_next      = '0;
            mismatch_next = 1'b0;
            if (!(mismatch | bit_bad)) begin
              state_next = OPEN;
              fail_next  = 4'd0;
            end else begin
              fail_next = fail_inc;
              if (fail_inc == TRIES_LIMIT) state_next = LOCKOUT;
            end
          end else begin
            cnt_next      = cnt + CW'(1);
            mismatch_next = mismatch | bit_bad;
          end
        end
      end
      OPEN: begin
        if (clr_press) begin
          state_next = ENTRY;
        end else if ((UNLOCK_CYCLES != 0) && (timer == UNLOCK_LAST)) begin
          state_next = ENTRY;
        end else if (UNLOCK_CYCLES != 0) begin
          timer_next = timer + TW'(1);
        end
      end
      LOCKOUT: begin
        if (timer == LOCK_LAST) begin
          state_next = ENTRY;
          fail_next  = 4'd0;
        end else begin
          timer_next = timer + TW'(1);
        end
      end
      default: state_next = ENTRY;
    endcase

    case (state)
      ENTRY: begin
        case (cnt_disp)
          3'd0:    seg = 7'b0111111;
          3'd1:    seg = 7'b0000110;
          3'd2:    seg = 7'b1011011;
          3'd3:    seg = 7'b1001111;
          3'd4:    seg = 7'b1100110;
          3'd5:    seg = 7'b1101101;
          3'd6:    seg = 7'b1111101;
          default: seg = 7'b0000111;
        endcase
      end
      OPEN:    seg = 7'b1110011;
      LOCKOUT: seg = 7'b1111001;
      default: seg = 7'b0111111;
    endcase
  end

  assign bus.sel       = 1'b1;
  assign bus.led_open  = (state == OPEN);
  assign bus.led_alarm = (state == LOCKOUT);
  assign bus.fail_cnt  = fail_cnt;
  assign bus.digital   = seg;

endmodule

// File: tb/tb_code_lock_n.sv
// Directed bench for code_lock_n.
// dut uses the default parameters.
// dut2 uses a one-bit code 0 with MAX_TRIES=1, auto-relock disabled and LOCKOUT_CYCLES=5.
// Inputs change on the falling edge, and outputs are sampled on the falling edge.
module tb_code_lock_n;
  localparam logic [6:0] SEG0  = 7'b0111111;
  localparam logic [6:0] SEG1  = 7'b0000110;
  localparam logic [6:0] SEG2  = 7'b1011011;
  localparam logic [6:0] SEG3  = 7'b1001111;
  localparam logic [6:0] SEG_P = 7'b1110011;
  localparam logic [6:0] SEG_E = 7'b1111001;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   n;

  always #5 clk = ~clk;

  code_lock_n_if bus();
  code_lock_n_if bus2();

  code_lock_n dut (.clk(clk), .reset(reset), .bus(bus));

  code_lock_n #(
    .CODE_LEN(1), .CODE(1'b0), .MAX_TRIES(1),
    .UNLOCK_CYCLES(0), .LOCKOUT_CYCLES(5)
  ) dut2 (.clk(clk), .reset(reset), .bus(bus2));

  // One press on dut; the outputs reflect it when the task returns.
  task automatic press1(input logic c, input logic z, input logic o);
    @(negedge clk);
    bus.clr_in = c; bus.b0_in = z; bus.b1_in = o;
    @(negedge clk);
    bus.clr_in = 1'b0; bus.b0_in = 1'b0; bus.b1_in = 1'b0;
  endtask

  // One press on dut2.
  task automatic press2(input logic c, input logic z, input logic o);
    @(negedge clk);
    bus2.clr_in = c; bus2.b0_in = z; bus2.b1_in = o;
    @(negedge clk);
    bus2.clr_in = 1'b0; bus2.b0_in = 1'b0; bus2.b1_in = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    checks++; if (bus.digital !== SEG0) begin errors++; $display("[TB] FAIL reset_digital: got %b expected %b", bus.digital, SEG0); end
    checks++; if (bus.led_open !== 1'b0) begin errors++; $display("[TB] FAIL reset_led_open: got %b expected 0", bus.led_open); end
    checks++; if (bus.led_alarm !== 1'b0) begin errors++; $display("[TB] FAIL reset_led_alarm: got %b expected 0", bus.led_alarm); end
    checks++; if (bus.fail_cnt !== 4'd0) begin errors++; $display("[TB] FAIL reset_fail_cnt: got %0d expected 0", bus.fail_cnt); end
    checks++; if (bus.sel !== 1'b1) begin errors++; $display("[TB] FAIL reset_sel: got %b expected 1", bus.sel); end
    checks++; if (bus2.digital !== SEG0) begin errors++; $display("[TB] FAIL reset2_digital: got %b expected %b", bus2.digital, SEG0); end
  endtask

  task automatic test_open;
    press1(0, 0, 1);
    checks++; if (bus.digital !== SEG1) begin errors++; $display("[TB] FAIL open_step1: got %b expected %b", bus.digital, SEG1); end
    press1(0, 1, 0);
    checks++; if (bus.digital !== SEG2) begin errors++; $display("[TB] FAIL open_step2: got %b expected %b", bus.digital, SEG2); end
    press1(0, 0, 1);
    checks++; if (bus.digital !== SEG3) begin errors++; $display("[TB] FAIL open_step3: got %b expected %b", bus.digital, SEG3); end
    press1(0, 0, 1);
    checks++; if (bus.led_open !== 1'b1) begin errors++; $display("[TB] FAIL open_led: got %b expected 1", bus.led_open); end
    checks++; if (bus.digital !== SEG_P) begin errors++; $display("[TB] FAIL open_digital: got %b expected %b", bus.digital, SEG_P); end
    checks++; if (bus.fail_cnt !== 4'd0) begin errors++; $display("[TB] FAIL open_fail_cnt: got %0d expected 0", bus.fail_cnt); end
    n = 0;
    while (bus.led_open === 1'b1 && n < 300) begin n++; @(negedge clk); end
    checks++; if (n !== 100) begin errors++; $display("[TB] FAIL open_duration: got %0d cycles expected 100", n); end
    checks++; if (bus.digital !== SEG0) begin errors++; $display("[TB] FAIL relock_digital: got %b expected %b", bus.digital, SEG0); end
  endtask

  task automatic test_lockout;
    for (int t = 1; t <= 2; t++) begin
      for (int b = 0; b < 4; b++) press1(0, 0, 1);
      checks++; if (bus.fail_cnt !== 4'(t)) begin errors++; $display("[TB] FAIL lock_fail_cnt%0d: got %0d expected %0d", t, bus.fail_cnt, t); end
      checks++; if (bus.digital !== SEG0) begin errors++; $display("[TB] FAIL lock_digital%0d: got %b expected %b", t, bus.digital, SEG0); end
    end
    for (int b = 0; b < 4; b++) press1(0, 0, 1);
    checks++; if (bus.led_alarm !== 1'b1) begin errors++; $display("[TB] FAIL lock_alarm: got %b expected 1", bus.led_alarm); end
    checks++; if (bus.digital !== SEG_E) begin errors++; $display("[TB] FAIL lock_digital_E: got %b expected %b", bus.digital, SEG_E); end
    n = 0;
    while (bus.led_alarm === 1'b1 && n < 400) begin
      n++;
      if (n == 10) bus.b1_in = 1'b1;
      if (n == 11) bus.b1_in = 1'b0;
      if (n == 20) bus.clr_in = 1'b1;
      if (n == 21) bus.clr_in = 1'b0;
      if (n == 30) begin
        checks++; if (bus.digital !== SEG_E) begin errors++; $display("[TB] FAIL lock_ignores_press: got %b expected %b", bus.digital, SEG_E); end
      end
      @(negedge clk);
    end
    checks++; if (n !== 200) begin errors++; $display("[TB] FAIL lock_duration: got %0d cycles expected 200", n); end
    checks++; if (bus.fail_cnt !== 4'd0) begin errors++; $display("[TB] FAIL lock_exit_fail_cnt: got %0d expected 0", bus.fail_cnt); end
    checks++; if (bus.digital !== SEG0) begin errors++; $display("[TB] FAIL lock_exit_digital: got %b expected %b", bus.digital, SEG0); end
  endtask

  task automatic test_clr_open;
    press1(0, 0, 1); press1(0, 1, 0); press1(0, 0, 1); press1(0, 0, 1);
    repeat (9) @(negedge clk);
    checks++; if (bus.led_open !== 1'b1) begin errors++; $display("[TB] FAIL clr_open_before: got %b expected 1", bus.led_open); end
    press1(1, 0, 0);
    checks++; if (bus.led_open !== 1'b0) begin errors++; $display("[TB] FAIL clr_open_after: got %b expected 0", bus.led_open); end
    checks++; if (bus.digital !== SEG0) begin errors++; $display("[TB] FAIL clr_open_digital: got %b expected %b", bus.digital, SEG0); end
  endtask

  task automatic test_clear_entry;
    press1(0, 0, 1); press1(0, 1, 0);
    checks++; if (bus.digital !== SEG2) begin errors++; $display("[TB] FAIL clr_entry_pre: got %b expected %b", bus.digital, SEG2); end
    press1(1, 0, 0);
    checks++; if (bus.digital !== SEG0) begin errors++; $display("[TB] FAIL clr_entry_post: got %b expected %b", bus.digital, SEG0); end
    press1(0, 0, 1); press1(0, 1, 0); press1(0, 0, 1); press1(0, 0, 1);
    checks++; if (bus.led_open !== 1'b1) begin errors++; $display("[TB] FAIL clr_entry_open: got %b expected 1", bus.led_open); end
    press1(1, 0, 0);
    press1(0, 0, 1);
    press1(1, 0, 1);
    checks++; if (bus.digital !== SEG0) begin errors++; $display("[TB] FAIL clr_wins_over_bit: got %b expected %b", bus.digital, SEG0); end
    press1(0, 1, 1); press1(0, 1, 0); press1(0, 0, 1); press1(0, 0, 1);
    checks++; if (bus.fail_cnt !== 4'd1) begin errors++; $display("[TB] FAIL both_bits_fail_cnt: got %0d expected 1", bus.fail_cnt); end
    checks++; if (bus.led_open !== 1'b0) begin errors++; $display("[TB] FAIL both_bits_led_open: got %b expected 0", bus.led_open); end
  endtask

  task automatic test_hold_reset;
    for (int b = 0; b < 4; b++) press1(0, 1, 0);
    checks++; if (bus.fail_cnt !== 4'd2) begin errors++; $display("[TB] FAIL hold_pre_fail_cnt: got %0d expected 2", bus.fail_cnt); end
    @(negedge clk); bus.b1_in = 1'b1;
    repeat (50) @(negedge clk);
    checks++; if (bus.digital !== SEG1) begin errors++; $display("[TB] FAIL hold_single_press: got %b expected %b", bus.digital, SEG1); end
    bus.b1_in = 1'b0;
    press1(0, 1, 0);
    checks++; if (bus.digital !== SEG2) begin errors++; $display("[TB] FAIL hold_cnt2: got %b expected %b", bus.digital, SEG2); end
    @(negedge clk); reset = 1'b1; bus.b1_in = 1'b1;
    @(negedge clk); reset = 1'b0;
    checks++; if (bus.digital !== SEG0) begin errors++; $display("[TB] FAIL midreset_digital: got %b expected %b", bus.digital, SEG0); end
    checks++; if (bus.fail_cnt !== 4'd0) begin errors++; $display("[TB] FAIL midreset_fail_cnt: got %0d expected 0", bus.fail_cnt); end
    repeat (3) @(negedge clk);
    checks++; if (bus.digital !== SEG0) begin errors++; $display("[TB] FAIL held_through_reset: got %b expected %b", bus.digital, SEG0); end
    bus.b1_in = 1'b0;
    @(negedge clk);
    press1(0, 0, 1);
    checks++; if (bus.digital !== SEG1) begin errors++; $display("[TB] FAIL press_after_release: got %b expected %b", bus.digital, SEG1); end
    press1(1, 0, 0);
  endtask

  task automatic test_small;
    press2(0, 0, 1);
    checks++; if (bus2.led_alarm !== 1'b1) begin errors++; $display("[TB] FAIL small_alarm: got %b expected 1", bus2.led_alarm); end
    checks++; if (bus2.fail_cnt !== 4'd1) begin errors++; $display("[TB] FAIL small_fail_cnt: got %0d expected 1", bus2.fail_cnt); end
    n = 0;
    while (bus2.led_alarm === 1'b1 && n < 50) begin n++; @(negedge clk); end
    checks++; if (n !== 5) begin errors++; $display("[TB] FAIL small_lock_duration: got %0d cycles expected 5", n); end
    checks++; if (bus2.fail_cnt !== 4'd0) begin errors++; $display("[TB] FAIL small_exit_fail_cnt: got %0d expected 0", bus2.fail_cnt); end
    press2(0, 1, 0);
    checks++; if (bus2.digital !== SEG_P) begin errors++; $display("[TB] FAIL small_open: got %b expected %b", bus2.digital, SEG_P); end
    repeat (150) @(negedge clk);
    checks++; if (bus2.led_open !== 1'b1) begin errors++; $display("[TB] FAIL small_no_autorelock: got %b expected 1", bus2.led_open); end
    press2(1, 0, 0);
    checks++; if (bus2.led_open !== 1'b0) begin errors++; $display("[TB] FAIL small_clr_relock: got %b expected 0", bus2.led_open); end
  endtask

  // Runs every scenario in order and prints the summary line.
  initial begin
    bus.clr_in = 1'b0;  bus.b0_in = 1'b0;  bus.b1_in = 1'b0;
    bus2.clr_in = 1'b0; bus2.b0_in = 1'b0; bus2.b1_in = 1'b0;
    test_reset();
    test_open();
    test_lockout();
    test_clr_open();
    test_clear_entry();
    test_hold_reset();
    test_small();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/code_lock_n.md
CODE_LOCK_N -- requirements
Module: code_lock_n

Interface
REQ-001 Parameter CODE_LEN, default 4, meaning: code length in bits, legal range 1..8.
REQ-002 Parameter CODE, default 4'b1011 (CODE_LEN bits wide), meaning: secret code, entered MSB first, B1 = 1, B0 = 0.
REQ-003 Parameter MAX_TRIES, default 3, meaning: consecutive failed codes that trigger lockout, legal range 1..15.
REQ-004 Parameter UNLOCK_CYCLES, default 100, meaning: auto-relock time in OPEN; 0 disables auto-relock.
REQ-005 Parameter LOCKOUT_CYCLES, default 200, meaning: lockout duration, minimum 1.
REQ-006 One clock; reset is synchronous and active-high; ports named clk and reset.
REQ-007 clk  in  1  system clock, all state changes on its rising edge.
REQ-008 reset  in  1  synchronous active-high reset.
REQ-009 clr_in  in  1  debounced, clk-synchronous user-clear button level.
REQ-010 b0_in  in  1  debounced, clk-synchronous "0" button level.
REQ-011 b1_in  in  1  debounced, clk-synchronous "1" button level.
REQ-012 sel  out  1  display digit enable, constant 1.
REQ-013 led_open  out  1  high in OPEN only.
REQ-014 led_alarm  out  1  high in LOCKOUT only.
REQ-015 fail_cnt  out  4  consecutive failed-code count.
REQ-016 digital  out  7  segment pattern {g,f,e,d,c,b,a}, active-high.

Function
REQ-017 Each button input SHALL have a previous-value register; a press is in=1 while prev=0. Exactly one press per rising edge, regardless of hold time.
REQ-018 A press sampled at clock edge k SHALL take effect at edge k; its outputs SHALL be visible after edge k (one-cycle latency from input rise).
REQ-019 States SHALL be ENTRY, OPEN, LOCKOUT, with internal cnt (0..CODE_LEN-1), mismatch flag, and a timer sized by $clog2 of the larger cycle parameter.
REQ-020 ENTRY, on a B0 or B1 press: compare the pressed bit with CODE[CODE_LEN-1-cnt]; set mismatch if they differ; increment cnt.
REQ-021 ENTRY, on a press with cnt = CODE_LEN-1: the code is complete.
  - No mismatch (including this bit): go to OPEN; fail_cnt <= 0.
  - Otherwise: fail_cnt increments. If the new value equals MAX_TRIES, go to LOCKOUT; else stay in ENTRY.
  - In every case cnt <= 0 and mismatch <= 0.
REQ-022 B0 and B1 pressed in the same cycle SHALL count as one entered bit that always mismatches.
REQ-023 ENTRY, clr press: cnt <= 0, mismatch <= 0, fail_cnt unchanged. Clr in the same cycle as a bit press SHALL win, and the bit SHALL be discarded.
REQ-024 OPEN: the timer starts at 0 on entry. Return to ENTRY on a clr press, or when the timer reaches UNLOCK_CYCLES-1 (if UNLOCK_CYCLES ≠ 0). B0/B1 presses SHALL be ignored.
REQ-025 LOCKOUT: return to ENTRY after exactly LOCKOUT_CYCLES cycles, with fail_cnt <= 0. All presses, including clr, SHALL be ignored.
REQ-026 digital encoding:
  - ENTRY shows the decimal digit cnt: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111.
  - OPEN shows 'P' = 1110011.
  - LOCKOUT shows 'E' = 1111001.
REQ-027 Reset asserted in any state or mid-entry SHALL override all other events in that cycle.

Reset
REQ-028 After a reset cycle:
  - state = ENTRY; cnt = 0; mismatch = 0; fail_cnt = 0; timer = 0.
  - led_open = 0; led_alarm = 0; digital = 0111111; sel = 1.
  - All previous-value registers = 1, so a button held through reset produces no press until it is released.

Verification (defaults unless stated)
REQ-029 Press sequence B1,B0,B1,B1 -> digital steps 0,1,2,3, then led_open = 1, digital = 1110011, fail_cnt = 0.
REQ-030 Code 1,1,1,1 entered three times -> fail_cnt goes 1 then 2. On the third completion, led_alarm = 1 and digital = 1111001. Presses during lockout have no effect. After exactly 200 cycles: ENTRY, fail_cnt = 0, led_alarm = 0.
REQ-031 Enter the correct code, wait -> led_open drops exactly 100 cycles after it rose. A second run with a clr press at cycle 10 -> led_open drops after that clr edge.
REQ-032 B1,B0, then clr, then B1,B0,B1,B1 -> digital returns to 0 after the clr, and the lock opens. A separate run with a simultaneous B0+B1 press as bit 1 -> failed code, fail_cnt = 1.
REQ-033 b1_in held 50 cycles -> cnt increments once. Reset asserted with cnt = 2 and fail_cnt = 2 -> all reset values next cycle. b1_in held high through reset -> no press recorded.
REQ-034 CODE_LEN = 1, CODE = 1'b0, MAX_TRIES = 1: one B1 press -> LOCKOUT. After LOCKOUT_CYCLES, one B0 press -> OPEN.
